// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: FSM encoding, bubble word and PC step.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INSTR_C = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_C     = 32'h0000_0000;
  localparam logic [31:0] PC_INC         = 32'd4;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with load enable and asynchronous reset.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_VAL;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect/stall handling and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_C,
  parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc;
  logic [31:0] pc_d;
  logic        pc_load;
  logic        load_ifid;
  logic        flush;
  logic        set_misalign;

  logic        valid_q;
  logic [31:0] ifpc_q;
  logic [31:0] ifpc4_q;
  logic [31:0] instr_q;
  logic        misalign_q;
  logic [31:0] count_q;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (pc_load),
    .d_i    (pc_d),
    .q_o    (pc)
  );

  // Redirect is evaluated ahead of the state case so it overrides stall in every state.
  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    pc_d         = pc;
    load_ifid    = 1'b0;
    flush        = 1'b0;
    set_misalign = 1'b0;
    if (redirect_i) begin
      pc_load      = 1'b1;
      pc_d         = {redirect_pc_i[31:2], 2'b00};
      flush        = 1'b1;
      set_misalign = |redirect_pc_i[1:0];
      state_d      = BUBBLE;
    end else begin
      unique case (state_q)
        BOOT:   state_d = RUN;
        RUN: begin
          if (!stall_i) begin
            load_ifid = 1'b1;
            pc_load   = 1'b1;
            pc_d      = pc + PC_INC;
          end
        end
        BUBBLE: state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      ifpc_q     <= '0;
      ifpc4_q    <= '0;
      instr_q    <= BUBBLE_INSTR;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        valid_q <= 1'b0;
        instr_q <= BUBBLE_INSTR;
      end else if (load_ifid) begin
        valid_q <= 1'b1;
        ifpc_q  <= pc;
        ifpc4_q <= pc + PC_INC;
        instr_q <= imem_rdata_i;
        count_q <= count_q + 32'd1;
      end
      if (set_misalign) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign imem_addr_o   = pc;
  assign if_id_valid_o = valid_q;
  assign if_id_pc_o    = ifpc_q;
  assign if_id_pc4_o   = ifpc4_q;
  assign if_id_instr_o = instr_q;
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] BUBBLE_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        misalign;
  logic [31:0] fcount;
  logic [31:0] imem_key;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending-boot / pending-bubble flags plus architectural values.
  bit          m_boot;
  bit          m_bubble;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifpc4;
  logic [31:0] m_instr;
  bit          m_mis;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ imem_key;

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .BUBBLE_INSTR (BUBBLE_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_id_valid_o (valid),
    .if_id_pc_o    (if_pc),
    .if_id_pc4_o   (if_pc4),
    .if_id_instr_o (if_instr),
    .misalign_o    (misalign),
    .fetch_count_o (fcount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_bubble = 1'b0;
    m_pc     = 32'h0;
    m_valid  = 1'b0;
    m_ifpc   = 32'h0;
    m_ifpc4  = 32'h0;
    m_instr  = BUBBLE_W;
    m_mis    = 1'b0;
    m_cnt    = 32'h0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_valid});
    chk({tag, ".instr"}, if_instr, m_instr);
    if (m_valid) begin
      chk({tag, ".pc"}, if_pc, m_ifpc);
      chk({tag, ".pc4"}, if_pc4, m_ifpc4);
    end
    chk({tag, ".mis"}, {31'b0, misalign}, {31'b0, m_mis});
    chk({tag, ".cnt"}, fcount, m_cnt);
  endtask

  // Apply one clock of inputs, advance the model with the pre-edge values, then check.
  task automatic step(input bit s, input bit r, input logic [31:0] tgt, input string tag);
    stall       = s;
    redirect    = r;
    redirect_pc = tgt;
    @(posedge clk);
    if (r) begin
      m_pc     = {tgt[31:2], 2'b00};
      m_valid  = 1'b0;
      m_instr  = BUBBLE_W;
      m_mis    = m_mis | (tgt[1:0] != 2'b00);
      m_boot   = 1'b0;
      m_bubble = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (!s) begin
      m_valid = 1'b1;
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_instr = m_pc ^ imem_key;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] tgt;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_key    = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pc", if_pc, 32'h0);
    chk("reset.pc4", if_pc4, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    // Boot then sequential fetch from 0 with imem returning its address.
    step(0, 0, 32'h0, "boot");
    chk("boot.novalid", {31'b0, valid}, 32'h0);
    step(0, 0, 32'h0, "seq0");
    chk("seq0.pc", if_pc, 32'h0);
    chk("seq0.instr_addr", if_instr, 32'h0);
    step(0, 0, 32'h0, "seq4");
    chk("seq4.pc", if_pc, 32'h4);
    step(0, 0, 32'h0, "seq8");
    chk("seq8.pc", if_pc, 32'h8);
    // Stall hold for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, "stall");
      chk("stall.pc_hold", if_pc, 32'h8);
      chk("stall.cnt_hold", fcount, 32'd3);
    end
    // Redirect wins over stall; one bubble, then 0x40, 0x44.
    step(1, 1, 32'h40, "redir_stall");
    chk("redir.bubble_instr", if_instr, BUBBLE_W);
    step(0, 0, 32'h0, "bubble_out");
    chk("bubble.still_invalid", {31'b0, valid}, 32'h0);
    step(0, 0, 32'h0, "tgt40");
    chk("tgt40.pc", if_pc, 32'h40);
    step(0, 0, 32'h0, "tgt44");
    chk("tgt44.pc", if_pc, 32'h44);
    // Misaligned target.
    step(0, 1, 32'h42, "mis_redir");
    chk("mis.addr", imem_addr, 32'h40);
    chk("mis.flag", {31'b0, misalign}, 32'h1);
    step(0, 0, 32'h0, "mis_b");
    step(0, 0, 32'h0, "mis_f1");
    step(0, 0, 32'h0, "mis_f2");
    chk("mis.sticky", {31'b0, misalign}, 32'h1);
    // Redirect inside bubble restarts it; then wrap at the top of memory.
    step(0, 1, 32'h100, "r1");
    step(0, 1, 32'hFFFF_FFFC, "r2");
    step(0, 0, 32'h0, "wrap_b");
    chk("wrap.bubble", {31'b0, valid}, 32'h0);
    step(0, 0, 32'h0, "wrap_top");
    chk("wrap.pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", if_pc4, 32'h0);
    step(0, 0, 32'h0, "wrap_zero");
    chk("wrap.next", if_pc, 32'h0);

    // Randomized traffic with a varying memory pattern.
    for (int i = 0; i < 300; i++) begin
      imem_key = $urandom;
      case ($urandom_range(0, 3))
        0: tgt = $urandom;
        1: tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2: tgt = $urandom & 32'hFC;
        default: tgt = $urandom & 32'h3FC;
      endcase
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt, "rand");
    end

    // Asynchronous reset in the middle of a bubble.
    step(1, 1, 32'h200, "pre_async");
    stall    = 1'b1;
    redirect = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.pc", if_pc, 32'h0);
    chk("async_rst.pc4", if_pc4, 32'h0);
    @(negedge clk);
    stall    = 1'b0;
    redirect = 1'b0;
    reset    = 1'b0;
    step(0, 0, 32'h0, "post_boot");
    step(0, 0, 32'h0, "post_seq0");
    chk("post.pc0", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUBBLE_INSTR, default 32'h0000_0000, SHALL be the instruction word presented whenever if_id_valid_o is 0.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 stall_i  input  1  SHALL, when high, hold the PC and the IF/ID register (hazard hold from decode).
REQ-006 redirect_i  input  1  SHALL, when high, signal a taken branch or jump from a later stage.
REQ-007 redirect_pc_i  input  32  SHALL be the redirect target.
REQ-008 imem_addr_o  output  32  SHALL be the instruction memory word address, always equal to the current PC.
REQ-009 imem_rdata_i  input  32  SHALL be the combinational instruction-memory read data for imem_addr_o.
REQ-010 if_id_valid_o  output  1  SHALL mark a live instruction in the IF/ID register.
REQ-011 if_id_pc_o  output  32  SHALL be the PC of the IF/ID instruction.
REQ-012 if_id_pc4_o  output  32  SHALL be if_id_pc_o + 4.
REQ-013 if_id_instr_o  output  32  SHALL be the registered instruction word.
REQ-014 misalign_o  output  1  SHALL be a sticky flag set by a misaligned redirect target.
REQ-015 fetch_count_o  output  32  SHALL count instructions accepted into IF/ID with valid=1.

Function
REQ-016 The FSM SHALL have exactly three states: BOOT, RUN and BUBBLE.
REQ-017 BOOT SHALL be entered on reset, SHALL last one clock after reset deasserts, SHALL load nothing into IF/ID, and SHALL go to RUN.
REQ-018 In RUN with stall_i=0 and redirect_i=0, each clock SHALL load IF/ID with {valid=1, PC, PC+4, imem_rdata_i} and SHALL set PC to PC+4.
REQ-019 In RUN with stall_i=1 and redirect_i=0, the PC, the IF/ID register and fetch_count_o SHALL all hold.
REQ-020 On redirect_i=1 in any non-reset state, PC SHALL become {redirect_pc_i[31:2],2'b00}, IF/ID SHALL be flushed (valid=0, instr=BUBBLE_INSTR), and the FSM SHALL go to BUBBLE.
REQ-021 redirect_i SHALL take priority over stall_i when both are high in the same cycle.
REQ-022 BUBBLE SHALL last exactly one cycle with IF/ID invalid, then SHALL return to RUN fetching from the redirected PC; a further redirect in BUBBLE SHALL restart BUBBLE with the new target.
REQ-023 A redirect with redirect_pc_i[1:0] != 0 SHALL set misalign_o, which stays set until reset.
REQ-024 Fetch latency SHALL be one clock from imem_addr_o to if_id_instr_o.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-026 fetch_count_o SHALL wrap modulo 2^32.

Reset
REQ-027 While reset is high: PC=RESET_PC, FSM=BOOT, if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=BUBBLE_INSTR, misalign_o=0, fetch_count_o=0.
REQ-028 Assertion of reset mid-operation SHALL abandon any pending stall or redirect immediately, without waiting for a clock edge.

Structure
REQ-029 The FSM state encoding, BUBBLE_INSTR and the PC increment constant (4) SHALL be defined in the shared CPU package.
REQ-030 The PC register SHALL be a sub-module, pc_reg, with load enable and asynchronous reset; the IF/ID register and FSM SHALL stay in fetch_stage.

Verification
REQ-031 Scenario: reset released, no stall, imem returns its address -> BOOT cycle, then IF/ID pc 0,4,8 on successive clocks, with valid=1 from the second clock after release.
REQ-032 Scenario: stall_i high for 3 cycles at PC=8 -> IF/ID holds pc=4 and PC holds 8 for 3 cycles; fetch_count_o is unchanged.
REQ-033 Scenario: redirect_i with target 0x40 while stall_i=1 -> one bubble (valid=0, instr=BUBBLE_INSTR), then IF/ID pc=0x40, then 0x44.
REQ-034 Scenario: redirect to 0x42 -> PC=0x40 and misalign_o=1, which persists through subsequent fetches.
REQ-035 Scenario: redirect to 0xFFFF_FFFC -> next IF/ID pc 0xFFFF_FFFC with pc4=0, followed by pc 0.
REQ-036 Scenario: reset asserted asynchronously mid-BUBBLE -> all outputs take their REQ-027 values before the next clock edge.
